text_console_writer: RTL and testbench

//  Writer side of the text-mode video RAM that the VGA PPU scans out. Accepts a byte stream
//  (terminal-style ASCII) over a valid/ready handshake and turns it into write cycles on
//  the character-cell RAM port at address {row, col}: printable output, cursor control,

---
 rtl/text_console_writer.sv | 174 +++++++++++++++++
 tb/tb_text_console_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Writer side of the text-mode character RAM. It turns a terminal-style byte stream into
// cell writes, cursor moves, clear-screen and hardware scroll-up.
module text_console_writer #(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned COL_W     = 5,
  parameter int unsigned ROW_W     = 5,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ROW_W+COL_W-1:0] vram_addr,
  output logic [7:0]             vram_wdata,
  output logic                   vram_we,
  input  logic [7:0]             vram_rdata,
  output logic [ROW_W-1:0]       cursor_row,
  output logic [COL_W-1:0]       cursor_col,
  output logic                   busy
);

  localparam int unsigned AW = ROW_W + COL_W;
  localparam logic [AW-1:0]    LAST_A   = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0]    COLS_A   = AW'(COLS);
  localparam logic [AW-1:0]    LROW_A   = AW'((ROWS - 1) * COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [2:0] {IDLE, PUTC, SCRL_RD, SCRL_WR, FILL} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             adv_q, adv_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;

  // Outputs are computed for the state being entered, so they line up with that state's cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ptr_d   = ptr_q;
    adv_d   = adv_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_data)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d = '0;
              if (row_q < LAST_ROW) begin
                row_d = row_q + ROW_W'(1);
              end else begin
                state_d = SCRL_RD;
                ptr_d   = COLS_A;
                addr_d  = COLS_A;
              end
            end
            8'h08: begin
              if (col_q != '0) begin
                col_d   = col_q - COL_W'(1);
                adv_d   = 1'b0;
                state_d = PUTC;
                addr_d  = {row_q, col_q - COL_W'(1)};
                wdata_d = FILL_CHAR;
                we_d    = 1'b1;
              end
            end
            8'h0C: begin
              row_d   = '0;
              col_d   = '0;
              state_d = FILL;
              addr_d  = '0;
              wdata_d = FILL_CHAR;
              we_d    = 1'b1;
            end
            default: begin
              if (in_data >= 8'h20) begin
                adv_d   = 1'b1;
                state_d = PUTC;
                addr_d  = {row_q, col_q};
                wdata_d = in_data;
                we_d    = 1'b1;
              end
            end
          endcase
        end
      end
      PUTC: begin
        state_d = IDLE;
        if (adv_q) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q < LAST_ROW) begin
              row_d = row_q + ROW_W'(1);
            end else begin
              state_d = SCRL_RD;
              ptr_d   = COLS_A;
              addr_d  = COLS_A;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      SCRL_RD: begin
        state_d = SCRL_WR;
        addr_d  = ptr_q - COLS_A;
        we_d    = 1'b1;
      end
      SCRL_WR: begin
        if (ptr_q == LAST_A) begin
          state_d = FILL;
          addr_d  = LROW_A;
          wdata_d = FILL_CHAR;
          we_d    = 1'b1;
        end else begin
          state_d = SCRL_RD;
          ptr_d   = ptr_q + AW'(1);
          addr_d  = ptr_q + AW'(1);
        end
      end
      FILL: begin
        if (addr_q == LAST_A) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_q + AW'(1);
          we_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ptr_q   <= '0;
      adv_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ptr_q   <= ptr_d;
      adv_q   <= adv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Scroll copies pass the RAM's registered read data straight through, one cycle after the read.
  assign vram_wdata = (state_q == SCRL_WR) ? vram_rdata : wdata_q;
  assign vram_addr  = addr_q;
  assign vram_we    = we_q;
  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a synchronous character RAM model on the write port.
module tb_text_console_writer;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] vram_addr;
  logic [7:0] vram_wdata;
  logic       vram_we;
  logic [7:0] vram_rdata;
  logic [4:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  logic preload = 1'b0;
  logic [7:0] mem [0:1023];
  logic [17:0] wlog [$];

  text_console_writer dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_rdata(vram_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  // Read-first synchronous RAM; preload sets cell i to i[7:0].
  always @(posedge CLOCK) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end else if (vram_we === 1'b1) begin
      mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  always @(negedge CLOCK) begin
    if (vram_we === 1'b1) wlog.push_back({vram_addr, vram_wdata});
    if (in_ready === 1'b0) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge CLOCK);
    while (in_ready !== 1'b1 && n < 4000) begin
      @(negedge CLOCK);
      n++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $error("FAIL send_timeout observed=busy expected=ready");
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge CLOCK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    chk(tag, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int s, b0, bad;
    logic [17:0] e;

    // Reset state
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_wdata", 32'(vram_wdata), 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);

    // Single printable character
    send(8'h41);
    chk("putc_we", 32'(vram_we), 32'd1);
    chk("putc_addr", 32'(vram_addr), 32'h000);
    chk("putc_wdata", 32'(vram_wdata), 32'h41);
    chk("putc_busy", 32'(in_ready), 32'd0);
    @(posedge CLOCK);
    #1;
    chk("putc_we_drop", 32'(vram_we), 32'd0);
    chk("putc_ready", 32'(in_ready), 32'd1);
    chk("putc_col", 32'(cursor_col), 32'd1);
    chk("putc_row", 32'(cursor_row), 32'd0);

    // CR and an ignored control byte produce no write and no busy cycle
    s = wlog.size();
    b0 = busy_cnt;
    send(8'h0D);
    send(8'h01);
    @(posedge CLOCK);
    #1;
    chk("ctrl_nowrite", 32'(wlog.size() - s), 32'd0);
    chk("ctrl_nobusy", 32'(busy_cnt - b0), 32'd0);
    chk("cr_col", 32'(cursor_col), 32'd0);

    // Full row of printables wraps to the next row
    s = wlog.size();
    b0 = busy_cnt;
    for (int i = 0; i < 32; i++) send(8'(8'h30 + i));
    wait_idle("row_idle");
    chk("row_nwrites", 32'(wlog.size() - s), 32'd32);
    chk("row_busy", 32'(busy_cnt - b0), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      e = wlog[s + i];
      if (e !== {10'(i), 8'(8'h30 + i)}) bad++;
    end
    chk("row_seq", 32'(bad), 32'd0);
    chk("row_cur_row", 32'(cursor_row), 32'd1);
    chk("row_cur_col", 32'(cursor_col), 32'd0);

    // Backspace at (2,5), then at column 0
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    wait_idle("bs_pos_idle");
    chk("bs_pre_row", 32'(cursor_row), 32'd2);
    chk("bs_pre_col", 32'(cursor_col), 32'd5);
    send(8'h08);
    chk("bs_we", 32'(vram_we), 32'd1);
    chk("bs_addr", 32'(vram_addr), 32'h044);
    chk("bs_wdata", 32'(vram_wdata), 32'h20);
    wait_idle("bs_idle");
    chk("bs_col", 32'(cursor_col), 32'd4);
    send(8'h0D);
    s = wlog.size();
    b0 = busy_cnt;
    send(8'h08);
    @(posedge CLOCK);
    #1;
    chk("bs0_nowrite", 32'(wlog.size() - s), 32'd0);
    chk("bs0_nobusy", 32'(busy_cnt - b0), 32'd0);
    chk("bs0_col", 32'(cursor_col), 32'd0);

    // Clear screen
    s = wlog.size();
    b0 = busy_cnt;
    send(8'h0C);
    wait_idle("ff_idle");
    chk("ff_busy", 32'(busy_cnt - b0), 32'd960);
    chk("ff_nwrites", 32'(wlog.size() - s), 32'd960);
    bad = 0;
    for (int i = 0; i < 960; i++) begin
      e = wlog[s + i];
      if (e !== {10'(i), 8'h20}) bad++;
    end
    chk("ff_seq", 32'(bad), 32'd0);
    chk("ff_row", 32'(cursor_row), 32'd0);
    chk("ff_col", 32'(cursor_col), 32'd0);

    // Scroll from the last row with a preloaded RAM
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h62);
    wait_idle("scr_pos_idle");
    chk("scr_pre_row", 32'(cursor_row), 32'd29);
    chk("scr_pre_col", 32'(cursor_col), 32'd7);
    @(negedge CLOCK);
    preload = 1'b1;
    @(negedge CLOCK);
    preload = 1'b0;
    s = wlog.size();
    b0 = busy_cnt;
    send(8'h0A);
    wait_idle("scr_idle");
    chk("scr_busy", 32'(busy_cnt - b0), 32'd1888);
    chk("scr_nwrites", 32'(wlog.size() - s), 32'd960);
    bad = 0;
    for (int a = 0; a < 960; a++) begin
      if (a < 928) begin
        if (mem[a] !== 8'(a + 32)) bad++;
      end else begin
        if (mem[a] !== 8'h20) bad++;
      end
    end
    chk("scr_ram", 32'(bad), 32'd0);
    chk("scr_row", 32'(cursor_row), 32'd29);
    chk("scr_col", 32'(cursor_col), 32'd0);

    // Reset in the middle of a scroll
    send(8'h0A);
    repeat (50) @(posedge CLOCK);
    #1;
    for (int n = 0; n < 4 && vram_we !== 1'b1; n++) begin
      @(posedge CLOCK);
      #1;
    end
    chk("mid_we_seen", 32'(vram_we), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_we_async", 32'(vram_we), 32'd0);
    chk("mid_addr_async", 32'(vram_addr), 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_row", 32'(cursor_row), 32'd0);
    chk("mid_col", 32'(cursor_col), 32'd0);
    send(8'h5A);
    chk("post_addr", 32'(vram_addr), 32'h000);
    chk("post_wdata", 32'(vram_wdata), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
